// File: rtl/tcg_pkg.sv
// -----------------------------------------------------------------------------
// tcg_pkg
// Shared constants and types for the text overlay renderer and its
// character-generator ROM interface.
//   CHAR_W         width of a character code
//   GROW_W         width of the glyph row index
//   GLYPH_W        width of one glyph row (MSB = leftmost pixel)
//   TCG_ADDR_W     character ROM address width {char, glyph_row}
//   ATTR_BLINK_BIT position of the blink attribute in a stored text cell
//   text_cell_t    one stored text cell {attr, code}
// -----------------------------------------------------------------------------
package tcg_pkg;

    localparam int CHAR_W         = 6;
    localparam int GROW_W         = 3;
    localparam int GLYPH_W        = 8;
    localparam int TCG_ADDR_W     = 9;
    localparam int ATTR_BLINK_BIT = 6;

    typedef struct packed {
        logic              attr;
        logic [CHAR_W-1:0] code;
    } text_cell_t;

endpackage

// File: rtl/text_buffer.sv
// -----------------------------------------------------------------------------
// text_buffer
// Simple dual-port RAM holding the text cells. One write port, one
// synchronous read port, read-first: a read and a write to the same address
// on the same edge return the value stored before that edge.
// There is no reset; contents rely on the device's zero initialisation at
// configuration time, so power-up cells hold code 0 (renders blank).
// Ports:
//   clk      clock
//   wr_en    write strobe
//   wr_addr  write address
//   wr_data  write data
//   rd_addr  read address (sampled every edge)
//   rd_data  registered read data, valid the cycle after rd_addr
// -----------------------------------------------------------------------------
module text_buffer #(
    parameter int AW = 7,
    parameter int DW = 7
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    // Both statements are non-blocking, so the read sees the pre-write value.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/text_overlay_renderer.sv
// -----------------------------------------------------------------------------
// text_overlay_renderer
// HUD/score text layer. For each raster pixel it locates the text cell,
// reads the character code from the text buffer, drives the character ROM
// address and registers the selected glyph bit. Fixed latency of 2 cycles
// from pixel input to text_on/out_valid.
//
// Optional feature macro: BLINK_EN. When defined, cells with the blink
// attribute are blanked during the odd half of a frame-counted blink period.
// Without it the attribute is stored but ignored and frame_start is unused.
//
// Ports:
//   clk          pixel clock
//   reset        asynchronous, active-high reset
//   pix_valid    hcount/vcount valid this cycle
//   hcount       current pixel x
//   vcount       current pixel y
//   frame_start  one-cycle pulse per frame (blink timing only)
//   wr_en        text buffer write strobe
//   wr_addr      text buffer write address {row, col}
//   wr_char      cell to write: bit6 = blink attribute, [5:0] = code
//   tcg_addr     character ROM address {code, glyph_row}
//   tcg_data     character ROM data, combinational from tcg_addr
//   text_on      registered pixel, 1 = glyph pixel lit
//   out_valid    pix_valid delayed to align with text_on
// -----------------------------------------------------------------------------
module text_overlay_renderer
    import tcg_pkg::*;
#(
    parameter logic [9:0] X0           = 10'd16,
    parameter logic [9:0] Y0           = 10'd16,
    parameter int         COLS_LOG2    = 5,
    parameter int         ROWS_LOG2    = 2,
    parameter int         BLINK_FRAMES = 30
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          pix_valid,
    input  logic [9:0]                    hcount,
    input  logic [9:0]                    vcount,
    input  logic                          frame_start,
    input  logic                          wr_en,
    input  logic [COLS_LOG2+ROWS_LOG2-1:0] wr_addr,
    input  logic [6:0]                    wr_char,
    output logic [TCG_ADDR_W-1:0]         tcg_addr,
    input  logic [GLYPH_W-1:0]            tcg_data,
    output logic                          text_on,
    output logic                          out_valid
);

    localparam int AW  = COLS_LOG2 + ROWS_LOG2;
    localparam int DXW = COLS_LOG2 + 3;
    localparam int DYW = ROWS_LOG2 + 3;
    localparam int DW  = $bits(text_cell_t);

    // Region edges at 11 bits so X0 + width cannot overflow.
    localparam logic [10:0] X_END = {1'b0, X0} + 11'(8 << COLS_LOG2);
    localparam logic [10:0] Y_END = {1'b0, Y0} + 11'(8 << ROWS_LOG2);

    // ---------------- S0: region check and buffer address ----------------
    logic           in_reg;
    logic [DXW-1:0] dx;
    logic [DYW-1:0] dy;
    logic [AW-1:0]  rd_addr;

    assign in_reg = ({1'b0, hcount} >= {1'b0, X0}) && ({1'b0, hcount} < X_END) &&
                    ({1'b0, vcount} >= {1'b0, Y0}) && ({1'b0, vcount} < Y_END);

    // Offsets are only formed inside the region, so they never wrap.
    always_comb begin
        dx = '0;
        dy = '0;
        if (in_reg) begin
            dx = DXW'(hcount - X0);
            dy = DYW'(vcount - Y0);
        end
    end

    assign rd_addr = {dy[DYW-1:3], dx[DXW-1:3]};

    // S1 registers. live_d1 folds pix_valid in so a bubble never lights a
    // pixel nor drives a ROM address.
    logic              live_d1;
    logic              valid_d1;
    logic [GROW_W-1:0] grow_d1;
    logic [2:0]        bidx_d1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            live_d1  <= 1'b0;
            valid_d1 <= 1'b0;
            grow_d1  <= '0;
            bidx_d1  <= '0;
        end else begin
            live_d1  <= in_reg & pix_valid;
            valid_d1 <= pix_valid;
            grow_d1  <= dy[2:0];
            bidx_d1  <= dx[2:0];
        end
    end

    // ---------------- Text buffer ----------------
    logic [DW-1:0] rd_q;

    text_buffer #(
        .AW (AW),
        .DW (DW)
    ) u_text_buffer (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_char),
        .rd_addr (rd_addr),
        .rd_data (rd_q)
    );

    // ---------------- S1: ROM address and glyph bit ----------------
    logic lit;
    logic blank;

    assign tcg_addr = live_d1 ? {rd_q[CHAR_W-1:0], grow_d1} : '0;
    // MSB of the glyph row is the leftmost pixel.
    assign lit      = live_d1 & tcg_data[3'(GLYPH_W-1) - bidx_d1];

`ifdef BLINK_EN
    localparam int BCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [BCW-1:0] blink_cnt;
    logic           blink_phase;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (frame_start) begin
            if (blink_cnt == BCW'(BLINK_FRAMES - 1)) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    assign blank = rd_q[ATTR_BLINK_BIT] & blink_phase;
`else
    logic unused_blink;
    assign unused_blink = &{1'b0, frame_start, rd_q[ATTR_BLINK_BIT], 1'(BLINK_FRAMES)};
    assign blank        = 1'b0;
`endif

    // ---------------- S2: registered outputs ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            text_on   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            text_on   <= lit & ~blank;
            out_valid <= valid_d1;
        end
    end

endmodule
